// File: rtl/cronometru_pkg.sv
// cronometru_pkg: shared state encoding, BCD digit type and helpers for the BCD stopwatch
package cronometru_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} stare_t;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
    function automatic bcd_t bcd_clamp(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction
endpackage

// File: rtl/bcd_cifra.sv
// bcd_cifra: one BCD digit register with up/down step and carry/borrow chaining
//   clock, reseteaza : clock and async active-low reset
//   clr_i, load_i    : synchronous clear (wins) and preload of val_i (clamped to 9)
//   en_i, jos_i      : step enable (tick AND incoming carry/borrow), direction (1 = down)
//   cifra_o, cout_o  : digit value, carry/borrow out to the next digit
module bcd_cifra
    import cronometru_pkg::*;
(
    input  logic clock,
    input  logic reseteaza,
    input  logic clr_i,
    input  logic load_i,
    input  bcd_t val_i,
    input  logic en_i,
    input  logic jos_i,
    output bcd_t cifra_o,
    output logic cout_o
);
    bcd_t cifra_q, cifra_d, pas;
    always_comb begin
        pas = jos_i ? ((cifra_q == 4'd0) ? BCD_MAX : cifra_q - 4'd1)
                    : ((cifra_q == BCD_MAX) ? 4'd0 : cifra_q + 4'd1);
        cifra_d = clr_i ? 4'd0 : load_i ? bcd_clamp(val_i) : en_i ? pas : cifra_q;
    end
    always_ff @(posedge clock or negedge reseteaza)
        if (!reseteaza) cifra_q <= 4'd0;
        else cifra_q <= cifra_d;
    assign cifra_o = cifra_q;
    assign cout_o = en_i & (jos_i ? (cifra_q == 4'd0) : (cifra_q == BCD_MAX));
endmodule

// File: rtl/cronometru_bcd_param.sv
// cronometru_bcd_param: parameterised BCD up/down stopwatch with prescaler, pause and optional lap
//   Inputs : clock, reseteaza (async active-low), start/sterge pulses, pauza level,
//            mod_jos (direction, latched on start), incarcare (down-count preload), tur (lap)
//   Outputs: cifre (live count), cifre_tur (lap value), stare (IDLE/RUN/PAUSE/DONE),
//            gata (count-down finished pulse), depasire (sticky up-count overflow)
//   Lap capture is compiled only with CRONOMETRU_LAP_EN; otherwise cifre_tur is 0.
module cronometru_bcd_param
    import cronometru_pkg::*;
#(
    parameter int NUM_CIFRE = 4,
    parameter int DIV_TICK  = 1
) (
    input  logic                   clock,
    input  logic                   reseteaza,
    input  logic                   start,
    input  logic                   pauza,
    input  logic                   sterge,
    input  logic                   mod_jos,
    input  logic [4*NUM_CIFRE-1:0] incarcare,
    input  logic                   tur,
    output logic [4*NUM_CIFRE-1:0] cifre,
    output logic [4*NUM_CIFRE-1:0] cifre_tur,
    output logic [1:0]             stare,
    output logic                   gata,
    output logic                   depasire
);
    localparam int W  = 4 * NUM_CIFRE;
    localparam int PW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV_TICK - 1);
    stare_t          stare_q, stare_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            jos_q, jos_d, gata_q, gata_d, dep_q, dep_d;
    logic [NUM_CIFRE:0] carry;
    logic            accept, tick;
    assign accept   = (stare_q == IDLE) && start && !sterge;
    assign tick     = (stare_q == RUN) && !pauza && (presc_q == PMAX);
    assign carry[0] = tick;
    for (genvar i = 0; i < NUM_CIFRE; i++) begin : g_cifra
        bcd_cifra u_cifra (
            .clock    (clock),
            .reseteaza(reseteaza),
            .clr_i    (sterge),
            .load_i   (accept),
            .val_i    (mod_jos ? incarcare[4*i+:4] : 4'd0),
            .en_i     (carry[i]),
            .jos_i    (jos_q),
            .cifra_o  (cifre[4*i+:4]),
            .cout_o   (carry[i+1])
        );
    end
    always_comb begin
        stare_d = stare_q;
        presc_d = presc_q;
        jos_d   = jos_q;
        gata_d  = 1'b0;
        dep_d   = dep_q;
        if (sterge) begin
            stare_d = IDLE;
            presc_d = '0;
            dep_d   = 1'b0;
        end else begin
            case (stare_q)
                IDLE: if (start) begin
                    jos_d   = mod_jos;
                    presc_d = '0;
                    // clamping never turns a nonzero digit into zero, so a zero raw preload means zero
                    gata_d  = mod_jos && (incarcare == '0);
                    stare_d = gata_d ? DONE : RUN;
                end
                RUN: if (pauza) stare_d = PAUSE;
                else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    // a down tick from 00..01 is the one that lands on zero
                    if (tick && jos_q && (cifre == W'(1))) begin
                        stare_d = DONE;
                        gata_d  = 1'b1;
                    end
                    if (tick && !jos_q && carry[NUM_CIFRE]) dep_d = 1'b1;
                end
                PAUSE: if (!pauza) stare_d = RUN;
                DONE: ;
            endcase
        end
    end
    always_ff @(posedge clock or negedge reseteaza)
        if (!reseteaza) begin
            stare_q <= IDLE;
            presc_q <= '0;
            jos_q   <= 1'b0;
            gata_q  <= 1'b0;
            dep_q   <= 1'b0;
        end else begin
            stare_q <= stare_d;
            presc_q <= presc_d;
            jos_q   <= jos_d;
            gata_q  <= gata_d;
            dep_q   <= dep_d;
        end
    assign stare    = stare_q;
    assign gata     = gata_q;
    assign depasire = dep_q;
`ifdef CRONOMETRU_LAP_EN
    logic [W-1:0] tur_q, tur_d;
    assign tur_d = sterge ? '0 : (tur && (stare_q == RUN || stare_q == PAUSE)) ? cifre : tur_q;
    always_ff @(posedge clock or negedge reseteaza)
        if (!reseteaza) tur_q <= '0;
        else tur_q <= tur_d;
    assign cifre_tur = tur_q;
`else
    logic unused_tur;
    assign unused_tur = tur;
    assign cifre_tur  = '0;
`endif
endmodule

// File: tb/tb_cronometru_bcd_param.sv
// tb_cronometru_bcd_param: directed checks of the BCD stopwatch (DIV_TICK=1 and DIV_TICK=5 instances)
module tb_cronometru_bcd_param;
    logic        clock = 1'b0, reseteaza = 1'b0, start = 1'b0, pauza = 1'b0, sterge = 1'b0;
    logic        mod_jos = 1'b0, tur = 1'b0;
    logic [15:0] incarcare = '0;
    logic [15:0] cifre0, tur0, cifre5, tur5;
    logic [1:0]  stare0, stare5;
    logic        gata0, dep0, gata5, dep5;
    int          vecs = 0, errs = 0;
`ifdef CRONOMETRU_LAP_EN
    localparam logic [15:0] LAP_EXP = 16'h0042;
`else
    localparam logic [15:0] LAP_EXP = 16'h0000;
`endif

    cronometru_bcd_param #(.NUM_CIFRE(4), .DIV_TICK(1)) u0 (
        .clock(clock), .reseteaza(reseteaza), .start(start), .pauza(pauza), .sterge(sterge),
        .mod_jos(mod_jos), .incarcare(incarcare), .tur(tur), .cifre(cifre0), .cifre_tur(tur0),
        .stare(stare0), .gata(gata0), .depasire(dep0));
    cronometru_bcd_param #(.NUM_CIFRE(4), .DIV_TICK(5)) u5 (
        .clock(clock), .reseteaza(reseteaza), .start(start), .pauza(pauza), .sterge(sterge),
        .mod_jos(mod_jos), .incarcare(incarcare), .tur(tur), .cifre(cifre5), .cifre_tur(tur5),
        .stare(stare5), .gata(gata5), .depasire(dep5));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_sterge();
        sterge = 1'b1;
        cyc(1);
        sterge = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_stare", stare0, 0);
        chk("rst_cifre", cifre0, 0);
        chk("rst_tur", tur0, 0);
        chk("rst_gata", gata0, 0);
        chk("rst_dep", dep0, 0);
        cyc(1);
        reseteaza = 1'b1;
        // up count wrap 9999 -> 0000
        mod_jos = 1'b0;
        pulse_start();
        chk("up_load", cifre0, 16'h0000);
        chk("up_run", stare0, 1);
        cyc(10);
        chk("up_carry", cifre0, 16'h0010);
        cyc(9989);
        chk("up_9999", cifre0, 16'h9999);
        chk("up_nodep", dep0, 0);
        cyc(1);
        chk("up_wrap", cifre0, 16'h0000);
        chk("up_dep", dep0, 1);
        chk("up_stay_run", stare0, 1);
        // sterge beats start in the same cycle
        sterge = 1'b1;
        start = 1'b1;
        cyc(1);
        sterge = 1'b0;
        start = 1'b0;
        chk("clr_stare", stare0, 0);
        chk("clr_cifre", cifre0, 0);
        chk("clr_dep", dep0, 0);
        chk("clr_stare5", stare5, 0);
        // prescaler 5 with pause
        pulse_start();
        cyc(12);
        chk("div_c12", cifre5, 16'h0002);
        chk("div_c12_run", stare5, 1);
        pauza = 1'b1;
        cyc(19);
        chk("div_c31", cifre5, 16'h0002);
        chk("div_pause", stare5, 2);
        pauza = 1'b0;
        cyc(3);
        chk("div_resume_hold", cifre5, 16'h0002);
        chk("div_resume_run", stare5, 1);
        cyc(1);
        chk("div_resume_tick", cifre5, 16'h0003);
        pulse_sterge();
        // down count from 0103
        mod_jos = 1'b1;
        incarcare = 16'h0103;
        pulse_start();
        chk("dn_load", cifre0, 16'h0103);
        chk("dn_run", stare0, 1);
        cyc(1);
        chk("dn_first", cifre0, 16'h0102);
        cyc(3);
        chk("dn_borrow", cifre0, 16'h0099);
        cyc(98);
        chk("dn_one", cifre0, 16'h0001);
        chk("dn_one_gata", gata0, 0);
        cyc(1);
        chk("dn_zero", cifre0, 16'h0000);
        chk("dn_done", stare0, 3);
        chk("dn_gata", gata0, 1);
        cyc(1);
        chk("dn_gata_once", gata0, 0);
        chk("dn_hold_done", stare0, 3);
        chk("dn_hold_zero", cifre0, 16'h0000);
        pulse_sterge();
        chk("dn_clr", stare0, 0);
        // preload clamp and zero preload
        incarcare = 16'h00A0;
        pulse_start();
        chk("clamp_load", cifre0, 16'h0090);
        pulse_sterge();
        incarcare = 16'h0000;
        pulse_start();
        chk("zero_done", stare0, 3);
        chk("zero_gata", gata0, 1);
        chk("zero_cifre", cifre0, 16'h0000);
        cyc(1);
        chk("zero_gata_once", gata0, 0);
        chk("zero_hold", stare0, 3);
        pulse_sterge();
        // lap capture
        mod_jos = 1'b0;
        pulse_start();
        cyc(42);
        chk("lap_pre", cifre0, 16'h0042);
        tur = 1'b1;
        cyc(1);
        tur = 1'b0;
        chk("lap_cifre", cifre0, 16'h0043);
        chk("lap_val", tur0, LAP_EXP);
        cyc(3);
        chk("lap_cont", cifre0, 16'h0046);
        chk("lap_keep", tur0, LAP_EXP);
        // asynchronous reset mid-count, checked before any clock edge
        #2 reseteaza = 1'b0;
        #1;
        chk("arst_stare", stare0, 0);
        chk("arst_cifre", cifre0, 0);
        chk("arst_tur", tur0, 0);
        chk("arst_gata", gata0, 0);
        chk("arst_dep", dep0, 0);
        chk("arst_cifre5", cifre5, 0);
        chk("arst_stare5", stare5, 0);
        cyc(1);
        reseteaza = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cronometru_bcd_param.md
CRONOMETRU_BCD_PARAM -- requirements
Module: cronometru_bcd_param

Interface
REQ-001 SHALL have parameter NUM_CIFRE, default 4, number of BCD digits (legal 2..8).
REQ-002 SHALL have parameter DIV_TICK, default 1, clock cycles per count tick (legal 1..2^24).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reseteaza  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; starts counting from IDLE.
REQ-006 SHALL have port pauza  input  1  level; while high, counting is frozen.
REQ-007 SHALL have port sterge  input  1  one-cycle pulse; synchronous clear back to IDLE.
REQ-008 SHALL have port mod_jos  input  1  0 = count up, 1 = count down; sampled only on accepted start.
REQ-009 SHALL have port incarcare  input  4*NUM_CIFRE  BCD preload for count-down; digit 0 in bits [3:0].
REQ-010 SHALL have port tur  input  1  lap-capture pulse (used only when lap feature is compiled in).
REQ-011 SHALL have port cifre  output  4*NUM_CIFRE  live BCD count; digit 0 least significant.
REQ-012 SHALL have port cifre_tur  output  4*NUM_CIFRE  captured lap value.
REQ-013 SHALL have port stare  output  2  state encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 SHALL have port gata  output  1  one-cycle pulse when count-down reaches zero.
REQ-015 SHALL have port depasire  output  1  sticky up-count overflow flag.

Function
REQ-016 SHALL run the FSM: IDLE -start-> RUN; RUN -pauza=1-> PAUSE; PAUSE -pauza=0-> RUN; RUN -down count hits 0-> DONE; IDLE/RUN/PAUSE/DONE -sterge-> IDLE.
REQ-017 SHALL, on accepted start, load cifre with 0 (up) or incarcare (down), each preload digit >9 clamped to 9.
REQ-018 SHALL ignore start outside IDLE; sterge has priority over start, tick, and tur in the same cycle.
REQ-019 SHALL use a prescaler counting 0..DIV_TICK-1 only in RUN with pauza=0, issuing a tick when it equals DIV_TICK-1, then wrapping to 0; DIV_TICK=1 ticks every cycle.
REQ-020 SHALL freeze the prescaler value during PAUSE and clear it to 0 on start and sterge.
REQ-021 SHALL apply a tick in the same edge: up mode increments BCD with ripple carry (9->0 carries); down mode decrements with borrow (0->9 borrows).
REQ-022 SHALL, on up-count tick from all-9s, wrap cifre to all-0s, set depasire, and remain in RUN.
REQ-023 SHALL, on down-count tick producing all-0s, enter DONE, hold cifre at 0, and assert gata for exactly one cycle.
REQ-024 SHALL, when start is accepted in down mode with clamped preload equal to 0, enter DONE next cycle and pulse gata once.
REQ-025 SHALL clear cifre to 0, depasire to 0, and cifre_tur to 0 on sterge.
REQ-026 SHALL not change cifre in IDLE, PAUSE, or DONE.
REQ-027 SHALL register all outputs; cifre reflects a tick one cycle after the tick edge's inputs.

Reset
REQ-028 SHALL, on reseteaza=0, immediately set stare=IDLE, cifre=0, cifre_tur=0, gata=0, depasire=0, prescaler=0, latched mode=up.
REQ-029 SHALL release reset synchronously to clock; first start accepted on the first edge after release.

Configuration
REQ-030 SHALL compile the lap feature only when CRONOMETRU_LAP_EN is defined: a tur pulse in RUN or PAUSE copies cifre (value pre-tick of that edge) into cifre_tur.
REQ-031 SHALL, without CRONOMETRU_LAP_EN, ignore tur and tie cifre_tur to 0, with port list unchanged.

Structure
REQ-032 SHALL place the state enum, BCD digit typedef (4 bits), and constants BCD_MAX=9 in shared package cronometru_pkg.
REQ-033 SHALL instantiate sub-module bcd_cifra NUM_CIFRE times (one digit: inc/dec enable, carry/borrow in and out, load, clear).

Verification
REQ-034 SHALL cover: NUM_CIFRE=4, DIV_TICK=1, up mode, start, 10000 cycles -> cifre wraps 9999->0000, depasire=1, stare=RUN.
REQ-035 SHALL cover: DIV_TICK=5, start, pauza high cycles 12-31 -> cifre=0002 at cycle 12 and still 0002 at cycle 31, counting resumes with prescaler preserved.
REQ-036 SHALL cover: down mode, incarcare=0x0103, start -> 103 ticks later stare=DONE, cifre=0000, gata high exactly one cycle.
REQ-037 SHALL cover: incarcare=0x00A0 down start -> loaded 0090; incarcare=0 down start -> DONE plus single gata.
REQ-038 SHALL cover: sterge and start same cycle in RUN -> IDLE, cifre=0; reseteaza low mid-count -> all outputs 0 without a clock edge.
REQ-039 SHALL cover with CRONOMETRU_LAP_EN: tur at cifre=0042 -> cifre_tur=0042 while cifre continues; without macro -> cifre_tur stays 0.
